// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: requester handshakes, register-file write/read side and perf counter.
// The master side drives requests and read data; the slave side is the arbiter.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int SCW  = 16
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               hold;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic [AW-1:0]      rd_addr1;
  logic [AW-1:0]      rd_addr2;
  logic [DW-1:0]      rf_rdata1;
  logic [DW-1:0]      rf_rdata2;
  logic [DW-1:0]      rd_data1;
  logic [DW-1:0]      rd_data2;
  logic [SCW-1:0]     stall_cnt;

  modport master (
    output req_valid, req_addr, req_data, hold, rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
    input  req_ready, rf_we, rf_waddr, rf_wdata, rd_data1, rd_data2, stall_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data, hold, rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
    output req_ready, rf_we, rf_waddr, rf_wdata, rd_data1, rd_data2, stall_cnt
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register file write port with a registered write stage.
// Optional macro WB_BYPASS_EN forwards the committing write to same-cycle reads.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int SCW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  rf_wb_arbiter_if.slave     bus
);
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0][AW-1:0] addr_a;
  logic [NREQ-1:0][DW-1:0] data_a;
  assign addr_a = bus.req_addr;
  assign data_a = bus.req_data;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx;
  logic            xfer;
  logic [NREQ-1:0] ready;
  logic            stall_hit;

  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SCW-1:0]  stall_q, stall_d;

  // Rotating priority search starting at ptr; hold and reset suppress any grant.
  always_comb begin
    int idx;
    gidx = '0;
    xfer = 1'b0;
    idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!xfer && bus.req_valid[idx]) begin
        xfer = 1'b1;
        gidx = idx[PW-1:0];
      end
    end
    if (bus.hold || !rst) begin
      xfer = 1'b0;
      gidx = '0;
    end
  end

  assign ready         = xfer ? (NREQ'(1) << gidx) : '0;
  assign bus.req_ready = ready;
  assign stall_hit     = |(bus.req_valid & ~ready);

  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    stall_d = stall_q;
    if (xfer) begin
      ptr_d   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      // x0 is hardwired: handshake completes but the write is dropped.
      we_d    = (addr_a[gidx] != '0);
      waddr_d = addr_a[gidx];
      wdata_d = data_a[gidx];
    end
    if (stall_hit && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      stall_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      stall_q <= stall_d;
    end
  end

  assign bus.rf_we     = we_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.stall_cnt = stall_q;

`ifdef WB_BYPASS_EN
  assign bus.rd_data1 = (we_q && (waddr_q == bus.rd_addr1) && (bus.rd_addr1 != '0))
                        ? wdata_q : bus.rf_rdata1;
  assign bus.rd_data2 = (we_q && (waddr_q == bus.rd_addr2) && (bus.rd_addr2 != '0))
                        ? wdata_q : bus.rf_rdata2;
`else
  assign bus.rd_data1 = bus.rf_rdata1;
  assign bus.rd_data2 = bus.rf_rdata2;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, round-robin, x0 writes, hold, saturation, bypass, async reset.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int SCW  = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  rf_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .SCW(SCW)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SCW(SCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] exp_rd1;
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.hold      = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr  = {5'd7, 5'd6, 5'd5};
    bus.req_data  = {32'hC, 32'hB, 32'hA};
    bus.rd_addr1  = '0;
    bus.rd_addr2  = '0;
    bus.rf_rdata1 = 32'h1234;
    bus.rf_rdata2 = 32'h0777;
    #2;
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_we",    64'(bus.rf_we),     64'h0);
    chk("rst_stall", 64'(bus.stall_cnt), 64'h0);
    chk("rst_waddr", 64'(bus.rf_waddr),  64'h0);

    // Release reset mid-cycle
    tick();
    rst = 1'b1;
    #1;
    chk("rel_ready", 64'(bus.req_ready), 64'h1);
    chk("rel_we",    64'(bus.rf_we),     64'h0);

    // All three valid: grants rotate 0,1,2,0,1,2
    for (int c = 0; c < 6; c++) begin
      chk("rr_ready", 64'(bus.req_ready), 64'(3'b001 << (c % 3)));
      tick();
      chk("rr_we",    64'(bus.rf_we),     64'h1);
      chk("rr_waddr", 64'(bus.rf_waddr),  64'(5 + (c % 3)));
      chk("rr_wdata", 64'(bus.rf_wdata),  64'(32'hA + (c % 3)));
      chk("rr_stall", 64'(bus.stall_cnt), 64'(c + 1));
    end

    // Idle cycle: write enable drops, address/data hold
    bus.req_valid = 3'b000;
    tick();
    chk("idle_we",    64'(bus.rf_we),     64'h0);
    chk("idle_waddr", 64'(bus.rf_waddr),  64'h7);
    chk("idle_stall", 64'(bus.stall_cnt), 64'h6);

    // Requester 1 alone writes x0
    bus.req_valid = 3'b010;
    bus.req_addr  = {5'd7, 5'd0, 5'd5};
    bus.req_data  = {32'hC, 32'hDEAD, 32'hA};
    #1;
    chk("x0_ready", 64'(bus.req_ready), 64'h2);
    tick();
    chk("x0_we",    64'(bus.rf_we),     64'h0);
    chk("x0_stall", 64'(bus.stall_cnt), 64'h6);
    // Pointer now 2: all valid -> requester 2; {0,1} valid -> requester 0
    bus.req_valid = 3'b111;
    #1;
    chk("ptr2_all", 64'(bus.req_ready), 64'h4);
    bus.req_valid = 3'b011;
    #1;
    chk("ptr2_wrap", 64'(bus.req_ready), 64'h1);

    // Hold for 4 cycles with requester 2 valid
    bus.req_valid = 3'b100;
    bus.req_addr  = {5'd9, 5'd0, 5'd5};
    bus.req_data  = {32'h99, 32'hDEAD, 32'hA};
    bus.hold      = 1'b1;
    #1;
    chk("hold_ready", 64'(bus.req_ready), 64'h0);
    for (int c = 0; c < 4; c++) tick();
    chk("hold_stall", 64'(bus.stall_cnt), 64'd10);
    chk("hold_we",    64'(bus.rf_we),     64'h0);
    bus.hold = 1'b0;
    #1;
    chk("unhold_ready", 64'(bus.req_ready), 64'h4);
    tick();
    chk("unhold_we",    64'(bus.rf_we),     64'h1);
    chk("unhold_waddr", 64'(bus.rf_waddr),  64'h9);
    chk("unhold_wdata", 64'(bus.rf_wdata),  64'h99);
    chk("unhold_stall", 64'(bus.stall_cnt), 64'd10);

    // Hold mid-stream: registered write completes, no new grant; counter saturates at 15
    bus.hold = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("sat_we",    64'(bus.rf_we),     64'h0);
    chk("sat_stall", 64'(bus.stall_cnt), 64'd15);

    // Write addr 6 / 0x55 from requester 1 (pointer is 0)
    bus.hold      = 1'b0;
    bus.req_valid = 3'b010;
    bus.req_addr  = {5'd9, 5'd6, 5'd5};
    bus.req_data  = {32'h99, 32'h55, 32'hA};
    #1;
    chk("byp_ready", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 3'b000;
    chk("byp_we",    64'(bus.rf_we),    64'h1);
    chk("byp_waddr", 64'(bus.rf_waddr), 64'h6);
    bus.rd_addr1 = 5'd6;
    bus.rd_addr2 = 5'd0;
`ifdef WB_BYPASS_EN
    exp_rd1 = 32'h55;
`else
    exp_rd1 = 32'h1234;
`endif
    #0.5;
    chk("byp_rd1_hit",  64'(bus.rd_data1), 64'(exp_rd1));
    chk("byp_rd2_zero", 64'(bus.rd_data2), 64'h0777);
    bus.rd_addr1 = 5'd0;
    bus.rd_addr2 = 5'd6;
    #0.5;
    chk("byp_rd1_zero", 64'(bus.rd_data1), 64'h1234);
`ifdef WB_BYPASS_EN
    chk("byp_rd2_hit",  64'(bus.rd_data2), 64'h55);
`else
    chk("byp_rd2_hit",  64'(bus.rd_data2), 64'h0777);
`endif

    // Asynchronous reset while rf_we=1, before the next edge
    bus.req_valid = 3'b111;
    #1;
    rst = 1'b0;
    #1;
    chk("arst_we",    64'(bus.rf_we),     64'h0);
    chk("arst_stall", 64'(bus.stall_cnt), 64'h0);
    chk("arst_ready", 64'(bus.req_ready), 64'h0);
    chk("arst_waddr", 64'(bus.rf_waddr),  64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
